// File: rtl/tinker_exec_ctrl.sv
// Multi-cycle execute controller: fetch operands, run ALU/divide/FPU op, write back.
// One instruction in flight; all control outputs decode directly from the state register.
module tinker_exec_ctrl #(
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic        rf_re,
   output logic [4:0]  rf_rs,
   output logic [4:0]  rf_rt,
   input  logic [63:0] rf_rs_data,
   input  logic [63:0] rf_rt_data,
   output logic [4:0]  ex_op,
   output logic [63:0] ex_a,
   output logic [63:0] ex_b,
   output logic [11:0] ex_l,
   input  logic [63:0] alu_result,
   output logic        fpu_start,
   input  logic        fpu_done,
   input  logic [63:0] fpu_result,
   output logic        rf_we,
   output logic [4:0]  rf_wd,
   output logic [63:0] rf_wdata,
   output logic        busy,
   output logic        illegal,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      IDLE, READ, EXEC, WAIT_DIV, WAIT_FPU, WB
   } state_t;

   localparam logic [4:0] OP_DIV   = 5'b11101;
   localparam logic [7:0] DIV_WAIT = 8'(DIV_LAT - 1);

   state_t      state, state_nxt;
   logic [31:0] instr_q;
   logic [63:0] ex_a_q, ex_b_q, result_q;
   logic [7:0]  div_cnt;
   logic        illegal_q;
   logic [31:0] retired_q;

   function automatic logic op_is_alu(input logic [4:0] op);
      case (op)
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00110,
         5'b10001, 5'b10010, 5'b11000, 5'b11010, 5'b11100: op_is_alu = 1'b1;
         default: op_is_alu = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_fpu(input logic [4:0] op);
      op_is_fpu = (op[4:2] == 3'b101);
   endfunction

   function automatic logic op_is_legal(input logic [4:0] op);
      op_is_legal = op_is_alu(op) || op_is_fpu(op) || (op == OP_DIV);
   endfunction

   logic cur_div, cur_fpu, div_zero;
   assign cur_div  = (instr_q[31:27] == OP_DIV);
   assign cur_fpu  = op_is_fpu(instr_q[31:27]);
   assign div_zero = (ex_b_q == 64'h0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (instr_valid && op_is_legal(instr[31:27])) state_nxt = READ;
         READ:     state_nxt = EXEC;
         EXEC: begin
            if (cur_fpu)
               state_nxt = WAIT_FPU;
            else if (cur_div && !div_zero && DIV_LAT > 1)
               state_nxt = WAIT_DIV;
            else
               state_nxt = WB;
         end
         WAIT_DIV: if (div_cnt == 8'd1) state_nxt = WB;
         WAIT_FPU: if (fpu_done) state_nxt = WB;
         WB:       state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         instr_q   <= '0;
         ex_a_q    <= '0;
         ex_b_q    <= '0;
         result_q  <= '0;
         div_cnt   <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state     <= state_nxt;
         illegal_q <= (state == IDLE) && instr_valid && !op_is_legal(instr[31:27]);
         if (state == IDLE && instr_valid)
            instr_q <= instr;
         if (state == READ) begin
            ex_a_q <= rf_rs_data;
            ex_b_q <= rf_rt_data;
         end
         case (state)
            EXEC: begin
               // divide by zero short-circuits to 0 instead of waiting out the divider
               if (cur_div) begin
                  if (div_zero)
                     result_q <= '0;
                  else if (DIV_LAT == 1)
                     result_q <= alu_result;
                  else
                     div_cnt <= DIV_WAIT;
               end else if (!cur_fpu) begin
                  result_q <= alu_result;
               end
            end
            WAIT_DIV: begin
               div_cnt <= div_cnt - 8'd1;
               if (div_cnt == 8'd1)
                  result_q <= alu_result;
            end
            WAIT_FPU: if (fpu_done) result_q <= fpu_result;
            WB:       retired_q <= retired_q + 32'd1;
            default: ;
         endcase
      end
   end

   assign instr_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign rf_re       = (state == READ);
   assign rf_rs       = instr_q[21:17];
   assign rf_rt       = instr_q[16:12];
   assign ex_op       = instr_q[31:27];
   assign ex_l        = instr_q[11:0];
   assign ex_a        = ex_a_q;
   assign ex_b        = ex_b_q;
   assign fpu_start   = (state == EXEC) && cur_fpu;
   assign rf_we       = (state == WB);
   assign rf_wd       = instr_q[26:22];
   assign rf_wdata    = result_q;
   assign illegal     = illegal_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_tinker_exec_ctrl.sv
// Scoreboard bench: expected write-backs queued at issue, checked when rf_we fires.
module tb_tinker_exec_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready, rf_re, fpu_start, rf_we, busy, illegal;
   logic [4:0]  rf_rs, rf_rt, ex_op, rf_wd;
   logic [63:0] rf_rs_data, rf_rt_data, ex_a, ex_b, alu_result, fpu_result, rf_wdata;
   logic [11:0] ex_l;
   logic        fpu_done, model_done, man_done;
   logic [31:0] retired;

   tinker_exec_ctrl #(.DIV_LAT(8)) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_re(rf_re), .rf_rs(rf_rs), .rf_rt(rf_rt),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_op(ex_op),
      .ex_a(ex_a), .ex_b(ex_b), .ex_l(ex_l), .alu_result(alu_result),
      .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_result(fpu_result),
      .rf_we(rf_we), .rf_wd(rf_wd), .rf_wdata(rf_wdata), .busy(busy),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   // register file and ALU reference
   logic [63:0] rf [32];
   assign rf_rs_data = rf[rf_rs];
   assign rf_rt_data = rf[rf_rt];

   always_comb begin
      alu_result = 64'h0;
      case (ex_op)
         5'b11000: alu_result = ex_a + ex_b;
         5'b10010: alu_result = {52'h0, ex_l};
         5'b11101: alu_result = (ex_b != 0) ? ex_a / ex_b : 64'h0;
         default:  alu_result = 64'h0;
      endcase
   end

   // FPU model: done pulse 5 cycles after start
   bit fpu_en;
   int fcnt = 0;
   int fs_cnt = 0;
   assign fpu_result = 64'h4004_0000_0000_0000;
   assign fpu_done   = model_done | man_done;

   always @(negedge clk) begin
      if (model_done) model_done = 1'b0;
      if (fpu_start) fs_cnt++;
      if (fpu_en && fpu_start) fcnt = 5;
      else if (fcnt > 0) begin
         fcnt--;
         if (fcnt == 0) model_done = 1'b1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  wd;
      logic [63:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (reset_n && rf_we) begin
         if (sb.size() == 0) chk("extra_we", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_rd", 64'(rf_wd), 64'(e.wd));
            chk("wb_data", rf_wdata, e.data);
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] l);
      mk = {op, rd, rs, rt, l};
   endfunction

   task automatic issue(input logic [31:0] ins, input int lat, input logic [63:0] d, input bit push);
      int n = 0;
      @(negedge clk);
      while (!instr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) chk("ready_timeout", 64'd0, 64'd1);
      instr = ins;
      instr_valid = 1'b1;
      if (push) sb.push_back('{wd: ins[26:22], data: d, cyc: cyc + lat});
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   int exp_ret = 0;

   initial begin
      reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
      man_done = 1'b0; model_done = 1'b0; fpu_en = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 64'h0;
      rf[1] = 64'd5; rf[2] = 64'd7;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_we", 64'(rf_we), 64'd0);
      chk("rst_re", 64'(rf_re), 64'd0);
      chk("rst_wdata", rf_wdata, 64'd0);
      chk("rst_ex_a", ex_a, 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(instr_ready), 64'd1);

      // add r3 = r1 + r2, with a second offer while busy that must be ignored
      issue(mk(5'b11000, 5'd3, 5'd1, 5'd2, 12'h0), 3, 64'd12, 1'b1);
      instr = mk(5'b10010, 5'd9, 5'd0, 5'd0, 12'h123);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      drain(); exp_ret++;
      chk("ret_add", 64'(retired), 64'(exp_ret));

      // mov literal
      issue(mk(5'b10010, 5'd4, 5'd0, 5'd0, 12'hABC), 3, 64'h0ABC, 1'b1);
      drain(); exp_ret++;

      // divide 100/7 and divide by zero; write to r0 as well
      rf[1] = 64'd100;
      issue(mk(5'b11101, 5'd6, 5'd1, 5'd2, 12'h0), 10, 64'd14, 1'b1);
      drain(); exp_ret++;
      rf[2] = 64'd0;
      issue(mk(5'b11101, 5'd0, 5'd1, 5'd2, 12'h0), 3, 64'd0, 1'b1);
      drain(); exp_ret++;
      chk("ret_div", 64'(retired), 64'(exp_ret));

      // FPU op
      fs_cnt = 0;
      issue(mk(5'b10100, 5'd5, 5'd1, 5'd2, 12'h0), 8, 64'h4004_0000_0000_0000, 1'b1);
      drain(); exp_ret++;
      chk("fpu_start_cnt", 64'(fs_cnt), 64'd1);

      // spurious fpu_done in IDLE
      fpu_en = 1'b0;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (4) @(negedge clk);
      chk("spur_busy", 64'(busy), 64'd0);
      chk("spur_ret", 64'(retired), 64'(exp_ret));

      // illegal opcode
      issue(mk(5'b01111, 5'd7, 5'd1, 5'd2, 12'h0), 0, 64'd0, 1'b0);
      chk("ill_pulse", 64'(illegal), 64'd1);
      chk("ill_ready", 64'(instr_ready), 64'd1);
      @(negedge clk);
      chk("ill_clear", 64'(illegal), 64'd0);
      repeat (4) @(negedge clk);
      chk("ill_ret", 64'(retired), 64'(exp_ret));

      // reset while waiting on the FPU, then a late fpu_done
      issue(mk(5'b10101, 5'd8, 5'd1, 5'd2, 12'h0), 0, 64'd0, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      repeat (4) @(negedge clk);
      exp_ret = 0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ready", 64'(instr_ready), 64'd1);
      chk("abort_ret", 64'(retired), 64'(exp_ret));

      // controller still functional after abort
      rf[2] = 64'd7;
      issue(mk(5'b11000, 5'd3, 5'd1, 5'd2, 12'h0), 3, 64'd107, 1'b1);
      drain(); exp_ret++;
      chk("post_ret", 64'(retired), 64'(exp_ret));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
